// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a two-lane 2:1 mux datapath between two show-ahead FIFOs.
// Grants are combinational; the selected word, its lane and a valid flag are registered.
module mux_rr_scheduler #(
    parameter int DATA_WIDTH = 4,
    parameter int BURST      = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  fifo_empty0,
    input  logic                  fifo_empty1,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  down_almost_full,
    output logic                  pop0,
    output logic                  pop1,
    output logic                  selector,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  count0,
    output logic [CNT_WIDTH-1:0]  count1
);

    typedef enum logic [1:0] {IDLE, SERVE, PAUSE} state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t     state;
    logic       rr_ptr;
    logic [3:0] burst_cnt;
    logic       pop_ok;
    logic       grant_valid;
    logic       grant_lane;

    // Backpressure reacts in the same cycle; the state register never gates pops.
    always_comb begin
        pop_ok      = reset_L && !down_almost_full;
        grant_valid = 1'b0;
        grant_lane  = 1'b0;
        if (pop_ok) begin
            if (!fifo_empty0 && !fifo_empty1) begin
                grant_valid = 1'b1;
                grant_lane  = (burst_cnt < BURST_L) ? rr_ptr : ~rr_ptr;
            end else if (!fifo_empty0) begin
                grant_valid = 1'b1;
                grant_lane  = 1'b0;
            end else if (!fifo_empty1) begin
                grant_valid = 1'b1;
                grant_lane  = 1'b1;
            end
        end
    end

    assign pop0 = grant_valid && !grant_lane;
    assign pop1 = grant_valid && grant_lane;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            selector  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            count0    <= '0;
            count1    <= '0;
        end else begin
            if (down_almost_full)
                state <= PAUSE;
            else if (!fifo_empty0 || !fifo_empty1)
                state <= SERVE;
            else
                state <= IDLE;

            if (grant_valid) begin
                // A lone lane keeps being granted; its burst count saturates at BURST.
                if (grant_lane == rr_ptr) begin
                    if (burst_cnt < BURST_L)
                        burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    rr_ptr    <= grant_lane;
                    burst_cnt <= 4'd1;
                end
                selector  <= grant_lane;
                valid_out <= 1'b1;
                data_out  <= grant_lane ? data_in1 : data_in0;
                if (grant_lane)
                    count1 <= count1 + CNT_WIDTH'(1);
                else
                    count0 <= count0 + CNT_WIDTH'(1);
            end else begin
                valid_out <= 1'b0;
                data_out  <= '0;
            end
        end
    end

    // A PAUSE state means the previous cycle was backpressured, so nothing can be valid now.
    always_ff @(posedge clk) begin
        if (state == PAUSE)
            assert (!valid_out);
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed vector table, corner sequences and
// randomized traffic compared against a grant-history reference model.
module tb_mux_rr_scheduler;

    localparam int DW    = 4;
    localparam int BURST = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          fifo_empty0 = 1'b1;
    logic          fifo_empty1 = 1'b1;
    logic [DW-1:0] data_in0 = '0;
    logic [DW-1:0] data_in1 = '0;
    logic          down_almost_full = 1'b0;
    logic          pop0, pop1, selector, valid_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count0, count1;

    mux_rr_scheduler #(.DATA_WIDTH(DW), .BURST(BURST), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_L(reset_L),
        .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
        .data_in0(data_in0), .data_in1(data_in1),
        .down_almost_full(down_almost_full),
        .pop0(pop0), .pop1(pop1),
        .selector(selector), .valid_out(valid_out), .data_out(data_out),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of granted lanes since reset
    bit hist[$];
    int m_cnt0, m_cnt1;
    bit m_valid, m_sel;
    int m_data;
    bit s_pop0, s_pop1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_grant(input bit rst, input bit e0, input bit e1,
                                        input bit daf, output bit gv, output bit gl);
        bit ptr;
        int run;
        ptr = (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && run < BURST; i--) begin
            if (hist[i] != ptr) break;
            run++;
        end
        gv = 1'b0;
        gl = 1'b0;
        if (rst && !daf) begin
            if (!e0 && !e1) begin
                gv = 1'b1;
                gl = (run < BURST) ? ptr : !ptr;
            end else if (!e0) begin
                gv = 1'b1;
            end else if (!e1) begin
                gv = 1'b1;
                gl = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit rst, input bit e0, input bit e1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit daf);
        bit gv, gl;
        @(negedge clk);
        reset_L = rst; fifo_empty0 = e0; fifo_empty1 = e1;
        data_in0 = d0; data_in1 = d1; down_almost_full = daf;
        #1;
        model_grant(rst, e0, e1, daf, gv, gl);
        s_pop0 = pop0;
        s_pop1 = pop1;
        chk("pop0", int'(pop0), int'(gv && !gl));
        chk("pop1", int'(pop1), int'(gv && gl));
        if (e1 && pop1) chk("pop1_while_empty", 1, 0);
        if (e0 && pop0) chk("pop0_while_empty", 1, 0);
        @(posedge clk);
        if (!rst) begin
            hist.delete();
            m_cnt0 = 0; m_cnt1 = 0; m_valid = 0; m_sel = 0; m_data = 0;
        end else if (gv) begin
            hist.push_back(gl);
            m_valid = 1; m_sel = gl;
            m_data = gl ? int'(d1) : int'(d0);
            if (gl) m_cnt1 = (m_cnt1 + 1) % (1 << CW);
            else    m_cnt0 = (m_cnt0 + 1) % (1 << CW);
        end else begin
            m_valid = 0; m_data = 0;
        end
        #1;
        chk("valid_out", int'(valid_out), int'(m_valid));
        chk("data_out", int'(data_out), m_data);
        if (m_valid || !rst) chk("selector", int'(selector), int'(m_sel));
        chk("count0", int'(count0), m_cnt0);
        chk("count1", int'(count1), m_cnt1);
    endtask

    typedef struct {
        bit            rst, e0, e1, daf;
        logic [DW-1:0] d0, d1;
        bit            p0, p1, v, s;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, input bit e0, input bit e1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit daf,
                                input bit p0, input bit p1, input bit v, input bit s,
                                input logic [DW-1:0] dout);
        vec_t r;
        r.rst = rst; r.e0 = e0; r.e1 = e1; r.d0 = d0; r.d1 = d1; r.daf = daf;
        r.p0 = p0; r.p1 = p1; r.v = v; r.s = s; r.dout = dout;
        tbl.push_back(r);
    endfunction

    initial begin
        // reset with both FIFOs non-empty, then lane 0 alone
        add(0, 0, 0, 4'h1, 4'h2, 0,  0, 0, 0, 0, 4'h0);
        add(0, 0, 0, 4'h1, 4'h2, 0,  0, 0, 0, 0, 4'h0);
        add(1, 0, 1, 4'h3, 4'h0, 0,  1, 0, 1, 0, 4'h3);
        add(1, 0, 1, 4'h5, 4'h0, 0,  1, 0, 1, 0, 4'h5);
        add(1, 0, 1, 4'h9, 4'h0, 0,  1, 0, 1, 0, 4'h9);
        add(1, 1, 1, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0);
        // fair bursts from a fresh reset
        add(0, 0, 0, 4'h7, 4'h8, 0,  0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 4'hA, 4'hB, 0,  1, 0, 1, 0, 4'hA);
        add(1, 0, 0, 4'hA, 4'hB, 0,  1, 0, 1, 0, 4'hA);
        add(1, 0, 0, 4'hA, 4'hB, 0,  0, 1, 1, 1, 4'hB);
        add(1, 0, 0, 4'hA, 4'hB, 0,  0, 1, 1, 1, 4'hB);
        add(1, 0, 0, 4'hA, 4'hB, 0,  1, 0, 1, 0, 4'hA);
        add(1, 0, 0, 4'hA, 4'hB, 0,  1, 0, 1, 0, 4'hA);
        add(1, 0, 0, 4'hA, 4'hB, 0,  0, 1, 1, 1, 4'hB);
        // backpressure mid-burst, then lane 1 finishes its burst
        add(1, 0, 0, 4'hA, 4'hB, 1,  0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 4'hA, 4'hB, 1,  0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 4'hA, 4'hB, 1,  0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 4'hA, 4'hB, 0,  0, 1, 1, 1, 4'hB);
        add(1, 0, 0, 4'hA, 4'hB, 0,  1, 0, 1, 0, 4'hA);
        // lane 1 empties while lane 0 has a full burst: lane 0 re-granted
        add(1, 0, 0, 4'hC, 4'hD, 0,  1, 0, 1, 0, 4'hC);
        add(1, 0, 1, 4'hE, 4'hD, 0,  1, 0, 1, 0, 4'hE);
        add(1, 0, 0, 4'hC, 4'hD, 0,  0, 1, 1, 1, 4'hD);
        // reset mid-burst drops the word on data_out
        add(0, 0, 0, 4'hC, 4'hD, 0,  0, 0, 0, 0, 4'h0);
        add(1, 0, 0, 4'h6, 4'h4, 0,  1, 0, 1, 0, 4'h6);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].e0, tbl[i].e1, tbl[i].d0, tbl[i].d1, tbl[i].daf);
            chk($sformatf("tbl%0d_pop0", i), int'(s_pop0), int'(tbl[i].p0));
            chk($sformatf("tbl%0d_pop1", i), int'(s_pop1), int'(tbl[i].p1));
            chk($sformatf("tbl%0d_valid", i), int'(valid_out), int'(tbl[i].v));
            chk($sformatf("tbl%0d_data", i), int'(data_out), int'(tbl[i].dout));
            if (tbl[i].v) chk($sformatf("tbl%0d_sel", i), int'(selector), int'(tbl[i].s));
        end

        // eight alternating-burst grants from reset leave the counters equal
        step(0, 1, 1, 4'h0, 4'h0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 4'(i), 4'(i + 8), 0);
        chk("fair_count_eq", int'(count0), int'(count1));
        chk("fair_count0", int'(count0), 4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(49) != 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
                 4'($urandom), 4'($urandom), ($urandom_range(4) == 0));
        end

        // counter wrap: 17 lane-0 transfers
        step(0, 1, 1, 4'h0, 4'h0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 1, 4'($urandom), 4'h0, 0);
        chk("wrap_count0", int'(count0), 1);
        chk("wrap_count1", int'(count1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
